// File: rtl/multirate_v4_div_25s_9ns_16_seq.sv
// Sequential radix-2 restoring divider: 25-bit signed dividend by 9-bit unsigned divisor,
// 16-bit signed saturated quotient plus signed remainder, valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for an operand pair, din_ready high
// CALC  | one restoring step per cycle on the dividend magnitude
// DONE  | first cycle registers the signed result, then holds it until dout_ready
module multirate_v4_div_25s_9ns_16_seq #(
  parameter int DIVIDEND_W = 25,
  parameter int DIVISOR_W  = 9,
  parameter int QUOT_W     = 16
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic                          din_valid,
  output logic                          din_ready,
  input  logic signed [DIVIDEND_W-1:0]  dividend,
  input  logic        [DIVISOR_W-1:0]   divisor,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic signed [QUOT_W-1:0]      quotient,
  output logic signed [DIVISOR_W:0]     remainder,
  output logic                          ovf,
  output logic                          dbz
);

  localparam int CNT_W = $clog2(DIVIDEND_W);

  localparam logic [DIVIDEND_W-1:0] POS_LIM = DIVIDEND_W'((1 << (QUOT_W-1)) - 1);
  localparam logic [DIVIDEND_W-1:0] NEG_LIM = DIVIDEND_W'(1 << (QUOT_W-1));
  localparam logic [QUOT_W-1:0]     Q_MAX   = {1'b0, {(QUOT_W-1){1'b1}}};
  localparam logic [QUOT_W-1:0]     Q_MIN   = {1'b1, {(QUOT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [DIVIDEND_W-1:0]   mag;
  logic [DIVISOR_W:0]      prem;
  logic [DIVISOR_W-1:0]    dvs_r;
  logic                    neg_r;
  logic                    zero_r;

  // Magnitude taken one bit wider so that -2^(DIVIDEND_W-1) does not wrap.
  logic [DIVIDEND_W:0]     dvd_ext;
  logic [DIVIDEND_W:0]     abs_wide;

  assign dvd_ext  = {dividend[DIVIDEND_W-1], dividend};
  assign abs_wide = dividend[DIVIDEND_W-1] ? (~dvd_ext + 1'b1) : dvd_ext;

  logic [DIVISOR_W:0]      prem_sh;
  logic [DIVISOR_W:0]      prem_nx;
  logic [DIVIDEND_W-1:0]   mag_nx;
  logic                    take;

  assign prem_sh = {prem[DIVISOR_W-1:0], mag[DIVIDEND_W-1]};
  assign take    = (prem_sh >= {1'b0, dvs_r});
  assign prem_nx = take ? (prem_sh - {1'b0, dvs_r}) : prem_sh;
  assign mag_nx  = {mag[DIVIDEND_W-2:0], take};

  // After CALC, mag holds the raw quotient magnitude and prem the remainder magnitude.
  logic                    sat;
  logic [QUOT_W-1:0]       q_mag;
  logic [QUOT_W-1:0]       q_signed;
  logic [DIVISOR_W:0]      r_signed;

  assign sat      = neg_r ? (mag > NEG_LIM) : (mag > POS_LIM);
  assign q_mag    = mag[QUOT_W-1:0];
  assign q_signed = neg_r ? (~q_mag + 1'b1) : q_mag;
  assign r_signed = neg_r ? (~prem + 1'b1) : prem;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      mag        <= '0;
      prem       <= '0;
      dvs_r      <= '0;
      neg_r      <= 1'b0;
      zero_r     <= 1'b0;
      din_ready  <= 1'b0;
      dout_valid <= 1'b0;
      quotient   <= '0;
      remainder  <= '0;
      ovf        <= 1'b0;
      dbz        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (din_valid && din_ready) begin
            din_ready <= 1'b0;
            dvs_r     <= divisor;
            neg_r     <= dividend[DIVIDEND_W-1];
            zero_r    <= (divisor == '0);
            mag       <= abs_wide[DIVIDEND_W-1:0];
            prem      <= '0;
            cnt       <= CNT_W'(DIVIDEND_W - 1);
            state     <= (divisor == '0) ? DONE : CALC;
          end else begin
            din_ready <= 1'b1;
          end
        end

        CALC: begin
          prem <= prem_nx;
          mag  <= mag_nx;
          if (cnt == '0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DONE: begin
          if (!dout_valid) begin
            dout_valid <= 1'b1;
            if (zero_r) begin
              quotient  <= neg_r ? Q_MIN : Q_MAX;
              remainder <= '0;
              ovf       <= 1'b1;
              dbz       <= 1'b1;
            end else if (sat) begin
              quotient  <= neg_r ? Q_MIN : Q_MAX;
              remainder <= '0;
              ovf       <= 1'b1;
              dbz       <= 1'b0;
            end else begin
              quotient  <= q_signed;
              remainder <= r_signed;
              ovf       <= 1'b0;
              dbz       <= 1'b0;
            end
          end else if (dout_ready) begin
            // din_ready is raised from IDLE one edge later, so no same-edge accept.
            dout_valid <= 1'b0;
            state      <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          din_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
